ascon_block_padder: RTL and testbench

//  Upstream feeder of the data-XOR stage. Collects associated-data or plaintext bytes over a

---
 rtl/ascon_block_padder.sv | 139 +++++++++++++
 tb/tb_ascon_block_padder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_block_padder.sv
// Packs a byte stream into 64-bit ASCON rate blocks with 0x80/zero padding; block valid the cycle after the completing byte.
// One block buffered: bytes are refused while a block waits, and the block is held until block_ready_i.
module ascon_block_padder #(
  parameter int          RATE_BYTES = 8,
  parameter logic [7:0]  PAD_BYTE   = 8'h80
) (
  input  logic                    clock_i,
  input  logic                    resetb_i,
  input  logic                    start_i,
  input  logic                    empty_i,
  input  logic                    mode_ad_i,
  input  logic [7:0]              byte_i,
  input  logic                    byte_valid_i,
  input  logic                    byte_last_i,
  output logic                    byte_ready_o,
  output logic [8*RATE_BYTES-1:0] block_o,
  output logic                    block_valid_o,
  output logic                    block_last_o,
  input  logic                    block_ready_i,
  output logic                    done_o
);

  localparam int BW = 8 * RATE_BYTES;
  localparam int CW = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;
  localparam logic [BW-1:0] PAD_BLK = {PAD_BYTE, {(BW-8){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic            last_q, last_d;
  logic            pad_q, pad_d;
  logic            done_q, done_d;
  logic            byte_hs, blk_hs;
  int              cnt_v;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    last_d  = last_q;
    pad_d   = pad_q;
    done_d  = 1'b0;
    byte_hs = byte_valid_i & byte_ready_o;
    blk_hs  = block_valid_o & block_ready_i;
    cnt_v   = int'(cnt_q);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (empty_i) begin
            if (mode_ad_i) begin
              done_d = 1'b1;
            end else begin
              state_d = S_OUT;
              buf_d   = PAD_BLK;
              last_d  = 1'b1;
            end
          end else begin
            state_d = S_FILL;
            cnt_d   = '0;
            buf_d   = '0;
            last_d  = 1'b0;
            pad_d   = 1'b0;
          end
        end
      end
      S_FILL: begin
        if (byte_hs) begin
          for (int k = 0; k < RATE_BYTES; k++) begin
            if (k == cnt_v)
              buf_d[BW-1-8*k -: 8] = byte_i;
            else if (byte_last_i && (k == cnt_v + 1))
              buf_d[BW-1-8*k -: 8] = PAD_BYTE;
          end
          if (cnt_v == RATE_BYTES - 1) begin
            // Full block on the last byte: padding needs a block of its own.
            state_d = S_OUT;
            cnt_d   = '0;
            last_d  = 1'b0;
            pad_d   = byte_last_i;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (byte_last_i) begin
              state_d = S_OUT;
              last_d  = 1'b1;
            end
          end
        end
      end
      S_OUT: begin
        if (blk_hs) begin
          if (last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            buf_d   = '0;
            last_d  = 1'b0;
          end else if (pad_q) begin
            buf_d  = PAD_BLK;
            last_d = 1'b1;
            pad_d  = 1'b0;
          end else begin
            state_d = S_FILL;
            cnt_d   = '0;
            buf_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o  = (state_q == S_FILL);
    block_valid_o = (state_q == S_OUT);
    block_o       = buf_q;
    block_last_o  = last_q;
    done_o        = done_q;
  end

endmodule

// File: tb/tb_ascon_block_padder.sv
// Randomised and directed stimulus for ascon_block_padder, checked every cycle against a padding model.
module tb_ascon_block_padder;

  logic        clock_i = 1'b0;
  logic        resetb_i;
  logic        start_i, empty_i, mode_ad_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i, byte_last_i;
  logic        byte_ready_o;
  logic [63:0] block_o;
  logic        block_valid_o, block_last_o;
  logic        block_ready_i;
  logic        done_o;

  ascon_block_padder #(.RATE_BYTES(8), .PAD_BYTE(8'h80)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .empty_i(empty_i),
    .mode_ad_i(mode_ad_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_last_i(byte_last_i), .byte_ready_o(byte_ready_o), .block_o(block_o),
    .block_valid_o(block_valid_o), .block_last_o(block_last_o),
    .block_ready_i(block_ready_i), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  int          nvec = 0, nerr = 0;
  logic [63:0] exp_blk_q[$];
  logic        exp_last_q[$];
  logic [63:0] model_log[$];
  logic [63:0] acc_log[$];
  logic [7:0]  msg_q[$];
  bit          msg_active = 0, exp_done = 0;
  int          done_cnt = 0;
  int          rdy_pct = 70;
  bit          prev_hold = 0;
  logic [63:0] prev_blk;
  logic        prev_last;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: append 0x80, zero-fill to a multiple of 8, cut into MSB-first blocks.
  // An empty message yields nothing for AD and a lone pad block for plaintext.
  function automatic void build_model(input bit ad);
    logic [7:0]  p[$];
    logic [63:0] blk;
    model_log.delete();
    p = msg_q;
    if (p.size() == 0 && ad) return;
    p.push_back(8'h80);
    while (p.size() % 8 != 0) p.push_back(8'h00);
    for (int b = 0; b < p.size(); b += 8) begin
      blk = '0;
      for (int j = 0; j < 8; j++) blk = {blk[55:0], p[b+j]};
      exp_blk_q.push_back(blk);
      exp_last_q.push_back(b + 8 >= p.size());
      model_log.push_back(blk);
    end
  endfunction

  initial begin
    block_ready_i = 1'b0;
    forever begin
      @(posedge clock_i);
      #1;
      block_ready_i = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  always @(negedge clock_i) begin
    bit          nd;
    logic [63:0] eb;
    logic        el;
    if (!resetb_i) begin
      check64("reset_flags", 64'({byte_ready_o, block_valid_o, block_last_o, done_o}), 64'h0);
      check64("reset_block", block_o, 64'h0);
      exp_blk_q.delete();
      exp_last_q.delete();
      msg_active = 0;
      exp_done   = 0;
      prev_hold  = 0;
    end else begin
      check64("done", 64'(done_o), 64'(exp_done));
      if (done_o) done_cnt++;
      check64("ready_vs_valid", 64'(byte_ready_o & block_valid_o), 64'h0);
      if (prev_hold) begin
        check64("hold_valid", 64'(block_valid_o), 64'h1);
        check64("hold_block", block_o, prev_blk);
        check64("hold_last", 64'(block_last_o), 64'(prev_last));
      end
      nd = 0;
      if (start_i && !msg_active) begin
        if (empty_i && mode_ad_i) nd = 1;
        else msg_active = 1;
      end
      if (block_valid_o && block_ready_i) begin
        acc_log.push_back(block_o);
        if (exp_blk_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_block: got %h last=%0b, none expected", block_o, block_last_o);
        end else begin
          eb = exp_blk_q.pop_front();
          el = exp_last_q.pop_front();
          check64("block", block_o, eb);
          check64("block_last", 64'(block_last_o), 64'(el));
          if (el) begin
            msg_active = 0;
            nd = 1;
          end
        end
      end
      exp_done  = nd;
      prev_hold = block_valid_o && !block_ready_i;
      prev_blk  = block_o;
      prev_last = block_last_o;
    end
  end

  task automatic run_msg(input bit ad, input int abort_after);
    int i = 0;
    int guard = 0;
    acc_log.delete();
    build_model(ad);
    @(posedge clock_i); #1;
    start_i = 1'b1; empty_i = (msg_q.size() == 0); mode_ad_i = ad;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    while (i < msg_q.size()) begin
      if (abort_after >= 0 && i >= abort_after) begin
        resetb_i = 1'b0; byte_valid_i = 1'b0; start_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1 resetb_i = 1'b1;
        return;
      end
      if (guard > 3000) begin
        nvec++; nerr++;
        $display("FAIL byte_feed_timeout: accepted %0d of %0d bytes", i, msg_q.size());
        return;
      end
      byte_i       = msg_q[i];
      byte_last_i  = (i == msg_q.size() - 1);
      byte_valid_i = ($urandom_range(0, 3) != 0);
      start_i      = ($urandom_range(0, 7) == 0);
      empty_i      = 1'($urandom_range(0, 1));
      mode_ad_i    = 1'($urandom_range(0, 1));
      @(posedge clock_i);
      if (byte_valid_i && byte_ready_o) i++;
      guard++;
      #1;
    end
    start_i = 1'b0;
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while ((msg_active || exp_blk_q.size() != 0) && g < 2000) begin
      byte_valid_i = 1'($urandom_range(0, 1));
      byte_i       = 8'($urandom);
      byte_last_i  = 1'($urandom_range(0, 1));
      @(posedge clock_i); #1;
      g++;
    end
    if (g >= 2000) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d blocks still expected", exp_blk_q.size());
    end
    byte_valid_i = 1'b0;
    repeat (2) begin @(posedge clock_i); #1; end
  endtask

  task automatic set_seq(input int n);
    msg_q.delete();
    for (int k = 0; k < n; k++) msg_q.push_back(8'(k));
  endtask

  initial begin
    int          d0;
    logic [63:0] cap;
    int          g;
    resetb_i = 1'b0; start_i = 1'b0; empty_i = 1'b0; mode_ad_i = 1'b0;
    byte_i = 8'h0; byte_valid_i = 1'b0; byte_last_i = 1'b0;

    // Reset held with random inputs, then idle with no start.
    repeat (6) begin
      start_i = 1'($urandom_range(0, 1)); empty_i = 1'($urandom_range(0, 1));
      mode_ad_i = 1'($urandom_range(0, 1)); byte_valid_i = 1'($urandom_range(0, 1));
      byte_i = 8'($urandom); byte_last_i = 1'($urandom_range(0, 1));
      @(posedge clock_i); #1;
    end
    start_i = 1'b0;
    resetb_i = 1'b1;
    repeat (5) begin
      byte_valid_i = 1'($urandom_range(0, 1));
      @(negedge clock_i);
      check64("idle_after_reset", 64'({byte_ready_o, block_valid_o}), 64'h0);
      @(posedge clock_i); #1;
    end
    byte_valid_i = 1'b0;

    // AD 01 02 03
    msg_q = '{8'h01, 8'h02, 8'h03};
    d0 = done_cnt;
    run_msg(1'b1, -1); wait_done();
    check64("model_t2", model_log[0], 64'h0102038000000000);
    check64("t2_count", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() > 0) check64("t2_block", acc_log[0], 64'h0102038000000000);
    check64("t2_done", 64'(done_cnt - d0), 64'd1);

    // 8 bytes: full block then a lone pad block
    set_seq(8);
    run_msg(1'b0, -1); wait_done();
    check64("model_t3a", model_log[0], 64'h0001020304050607);
    check64("model_t3b", model_log[1], 64'h8000000000000000);
    check64("t3_count", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() > 1) check64("t3_block1", acc_log[1], 64'h8000000000000000);

    // 10 bytes
    set_seq(10);
    run_msg(1'b1, -1); wait_done();
    check64("model_t4b", model_log[1], 64'h0809800000000000);
    check64("t4_count", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() > 1) check64("t4_block1", acc_log[1], 64'h0809800000000000);

    // Empty AD and empty plaintext
    msg_q.delete();
    d0 = done_cnt;
    run_msg(1'b1, -1); wait_done();
    check64("t5_ad_count", 64'(acc_log.size()), 64'd0);
    check64("t5_ad_done", 64'(done_cnt - d0), 64'd1);
    run_msg(1'b0, -1); wait_done();
    check64("t5_pt_count", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() > 0) check64("t5_pt_block", acc_log[0], 64'h8000000000000000);

    // Consumer stalls for 5 cycles with a block pending
    rdy_pct = 0;
    msg_q = '{8'hde, 8'had, 8'hbe, 8'hef};
    run_msg(1'b0, -1);
    g = 0;
    while (!block_valid_o && g < 100) begin @(posedge clock_i); #1; g++; end
    check64("t6_block_pending", 64'(block_valid_o), 64'h1);
    cap = block_o;
    repeat (5) begin
      byte_valid_i = 1'b1;
      @(negedge clock_i);
      check64("t6_stall_block", block_o, cap);
      check64("t6_stall_ready", 64'(byte_ready_o), 64'h0);
      @(posedge clock_i); #1;
    end
    rdy_pct = 70;
    wait_done();

    // Reset in the middle of FILL: partial block dropped, no done
    set_seq(6);
    d0 = done_cnt;
    run_msg(1'b1, 2);
    repeat (6) begin @(posedge clock_i); #1; end
    check64("t6_abort_done", 64'(done_cnt - d0), 64'd0);
    check64("t6_abort_idle", 64'({byte_ready_o, block_valid_o}), 64'h0);

    // Random messages
    for (int m = 0; m < 40; m++) begin
      msg_q.delete();
      for (int k = 0; k < int'($urandom_range(0, 20)); k++) msg_q.push_back(8'($urandom));
      rdy_pct = int'($urandom_range(30, 100));
      run_msg(1'($urandom_range(0, 1)), -1);
      wait_done();
    end

    check64("expect_drained", 64'(exp_blk_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
